// File: rtl/mrd_st_framer_if.sv
`default_nettype none
// ============================================================================
// Module : mrd_st_framer_if
// Desc   : Sample stream in (front end -> framer) and packet stream out
//          (framer -> memory top) bundled as one interface.
// Rev    : 1.0  initial release
// ============================================================================
interface mrd_st_framer_if #(
  parameter int DW = 18
);
  logic          s_valid;
  logic          s_ready;
  logic          s_sof;
  logic [11:0]   s_dftpts;
  logic [DW-1:0] s_real;
  logic [DW-1:0] s_imag;
  logic          dst_idle;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [11:0]   out_dftpts;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic          err_cfg;
  logic          err_drop;
  logic          err_sof;

  modport master (
    output s_valid, s_sof, s_dftpts, s_real, s_imag, dst_idle,
    input  s_ready, out_valid, out_sop, out_eop, out_dftpts, out_real, out_imag,
    input  err_cfg, err_drop, err_sof
  );

  modport slave (
    input  s_valid, s_sof, s_dftpts, s_real, s_imag, dst_idle,
    output s_ready, out_valid, out_sop, out_eop, out_dftpts, out_real, out_imag,
    output err_cfg, err_drop, err_sof
  );
endinterface
`default_nettype wire

// File: rtl/mrd_st_framer.sv
`default_nettype none
// ============================================================================
// Module : mrd_st_framer
// Desc   : Buffers DFT samples in a FIFO and frames them into sop/eop packets
//          towards the memory top, one sop per destination idle window.
// Rev    : 1.0  initial release
// ============================================================================
module mrd_st_framer #(
  parameter int DW         = 18,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_PTS    = 1200
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mrd_st_framer_if.slave bus
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          EW        = 1 + 12 + 2 * DW;
  localparam logic [11:0] C_MIN_PTS = 12'd12;
  localparam logic [11:0] C_MAX_PTS = 12'(MAX_PTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_full, fifo_empty, push, pop, ready;
  logic          h_sof;
  logic [11:0]   h_pts;
  logic [DW-1:0] h_re, h_im;

  state_t        state_q, state_d;
  logic [11:0]   len_q, len_d, cnt_q, cnt_d;
  logic          pkt_out_q, pkt_out_d;
  logic          valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [11:0]   pts_q, pts_d;
  logic [DW-1:0] re_q, re_d, im_q, im_d;
  logic          ecfg_q, ecfg_d, edrop_q, edrop_d, esof_q, esof_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign ready      = ~fifo_full & ~rst;
  assign push       = bus.s_valid & ready;
  assign {h_sof, h_pts, h_re, h_im} = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.s_sof, bus.s_dftpts, bus.s_real, bus.s_imag};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    // Any cycle with the destination busy proves it has left Idle.
    pkt_out_d = pkt_out_q & bus.dst_idle;
    pop       = 1'b0;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    pts_d     = pts_q;
    re_d      = re_q;
    im_d      = im_q;
    ecfg_d    = 1'b0;
    edrop_d   = 1'b0;
    esof_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!h_sof) begin
            pop     = 1'b1;
            edrop_d = 1'b1;
          end else if ((h_pts < C_MIN_PTS) || (h_pts > C_MAX_PTS)) begin
            pop    = 1'b1;
            ecfg_d = 1'b1;
          end else begin
            len_d   = h_pts;
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (bus.dst_idle && !pkt_out_q) begin
          pop       = 1'b1;
          valid_d   = 1'b1;
          sop_d     = 1'b1;
          pts_d     = len_q;
          re_d      = h_re;
          im_d      = h_im;
          cnt_d     = 12'd1;
          pkt_out_d = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          re_d    = h_re;
          im_d    = h_im;
          esof_d  = h_sof;
          cnt_d   = cnt_q + 12'd1;
          if (cnt_q + 12'd1 == len_q) begin
            eop_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      pkt_out_q <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      pts_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
      ecfg_q    <= 1'b0;
      edrop_q   <= 1'b0;
      esof_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      pkt_out_q <= pkt_out_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      pts_q     <= pts_d;
      re_q      <= re_d;
      im_q      <= im_d;
      ecfg_q    <= ecfg_d;
      edrop_q   <= edrop_d;
      esof_q    <= esof_d;
    end
  end

  assign bus.s_ready    = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_sop    = sop_q;
  assign bus.out_eop    = eop_q;
  assign bus.out_dftpts = pts_q;
  assign bus.out_real   = re_q;
  assign bus.out_imag   = im_q;
  assign bus.err_cfg    = ecfg_q;
  assign bus.err_drop   = edrop_q;
  assign bus.err_sof    = esof_q;
endmodule
`default_nettype wire
